lsu_controller: RTL and testbench

LSU_CONTROLLER -- requirements
Module: lsu_controller

---
 rtl/lsu_pkg.sv | 87 ++++++++
 rtl/lsu_controller.sv | 187 ++++++++++++++++++
 tb/tb_lsu_controller.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// funct3 codes, FSM states and byte-lane helpers.
package lsu_pkg;

   localparam int unsigned LSU_MEM_BYTES = 1024;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_RESP
   } lsu_state_e;

   // Index of the last byte of an access (N - 1).
   function automatic logic [1:0] last_idx(input logic [2:0] f3);
      logic [1:0] r;
      case (f3[1:0])
         2'b00:   r = 2'd0;
         2'b01:   r = 2'd1;
         default: r = 2'd3;
      endcase
      return r;
   endfunction

   // Stores only know B/H/W; loads add the unsigned variants.
   function automatic logic f3_legal(input logic wr,
                                     input logic [2:0] f3);
      logic r;
      r = 1'b0;
      unique case (1'b1)
         (f3 == F3_B),
         (f3 == F3_H),
         (f3 == F3_W):  r = 1'b1;
         (f3 == F3_BU),
         (f3 == F3_HU): r = !wr;
         default:       r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] get_byte(input logic [31:0] d,
                                           input logic [1:0]  idx);
      logic [7:0] r;
      case (idx)
         2'd0:    r = d[7:0];
         2'd1:    r = d[15:8];
         2'd2:    r = d[23:16];
         default: r = d[31:24];
      endcase
      return r;
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] d,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  b);
      logic [31:0] r;
      r = d;
      case (idx)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[23:16] = b;
         default: r[31:24] = b;
      endcase
      return r;
   endfunction

   // Sign/zero extension of the assembled load word.
   function automatic logic [31:0] ext_load(input logic [2:0]  f3,
                                            input logic [31:0] d);
      logic [31:0] r;
      case (f3)
         F3_B:    r = {{24{d[7]}}, d[7:0]};
         F3_H:    r = {{16{d[15]}}, d[15:0]};
         F3_BU:   r = {24'b0, d[7:0]};
         F3_HU:   r = {16'b0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_controller.sv
// Byte-serial load/store controller.
// One memory byte per cycle, little-endian, misaligned allowed.
module lsu_controller
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = LSU_MEM_BYTES
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic        write_q, write_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] asm_q, asm_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;

   logic [32:0] end_addr;
   logic        req_err;
   logic [1:0]  last_q;

   // End address is 33 bits wide so a top-of-space access cannot wrap.
   always_comb begin
      end_addr = {1'b0, req_addr} + {31'b0, last_idx(req_funct3)};
      req_err  = !f3_legal(req_write, req_funct3) ||
                 (end_addr >= 33'(MEM_BYTES));
      last_q   = last_idx(f3_q);
   end

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      f3_d         = f3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      asm_d        = asm_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = 32'b0;
      mem_wdata_d  = 8'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d     = req_write;
               f3_d        = req_funct3;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               cnt_d       = 2'd0;
               asm_d       = 32'b0;
               req_ready_d = 1'b0;
               if (req_err) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'b0;
               end else begin
                  state_d     = ST_ISSUE;
                  mem_en_d    = 1'b1;
                  mem_we_d    = req_write;
                  mem_addr_d  = req_addr;
                  mem_wdata_d = req_wdata[7:0];
               end
            end
         end
         ST_ISSUE: begin
            // Read data for the previous byte arrives this cycle.
            if (!write_q && (cnt_q != 2'd0)) begin
               asm_d = put_byte(asm_q, cnt_q - 2'd1, mem_rdata);
            end
            if (cnt_q == last_q) begin
               if (write_q) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
                  resp_rdata_d = 32'b0;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               cnt_d       = cnt_q + 2'd1;
               mem_en_d    = 1'b1;
               mem_we_d    = write_q;
               mem_addr_d  = addr_q + {30'b0, cnt_d};
               mem_wdata_d = write_q ? get_byte(wdata_q, cnt_d) : 8'b0;
            end
         end
         ST_DRAIN: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = ext_load(f3_q,
                              put_byte(asm_q, cnt_q, mem_rdata));
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d      = ST_IDLE;
               req_ready_d  = 1'b1;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = 32'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // State and registered outputs; reset aborts any access in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         write_q      <= 1'b0;
         f3_q         <= 3'b0;
         addr_q       <= 32'b0;
         wdata_q      <= 32'b0;
         cnt_q        <= 2'd0;
         asm_q        <= 32'b0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'b0;
         resp_err_q   <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'b0;
         mem_wdata_q  <= 8'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         f3_q         <= f3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         asm_q        <= asm_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller.
// A byte memory model answers the DUT one cycle after mem_en.
module tb_lsu_controller;
   import lsu_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'b0;
   logic [31:0] req_wdata = 32'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'b0;

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int n_en = 0;
   int c0 = 0;
   logic [7:0]  mem [0:1023];
   int          wr_cyc [$];
   logic [31:0] wr_addr [$];
   logic [7:0]  wr_data [$];

   always #5 clock = ~clock;

   lsu_controller #(.MEM_BYTES(1024)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Byte memory: write on enable, read data one cycle later.
   always @(posedge clock) begin
      if (mem_en) begin
         n_en++;
         if (mem_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            mem[mem_addr[9:0]] = mem_wdata;
         end
         mem_rdata <= mem[mem_addr[9:0]];
      end
      cyc++;
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_req(input  logic        w,
                         input  logic [2:0]  f3,
                         input  logic [31:0] a,
                         input  logic [31:0] d,
                         output int          lat,
                         output logic [31:0] rd,
                         output logic        er);
      int guard;
      guard = 0;
      @(negedge clock);
      while (!req_ready && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      c0  = cyc - 1;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
   endtask

   task automatic ack(input string tag);
      @(negedge clock);
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      resp_ready = 1'b0;
      check({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_idle_valid"}, 64'(resp_valid), 64'd0);
   endtask

   task automatic xact(input string       tag,
                       input logic        w,
                       input logic [2:0]  f3,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [31:0] exp_rd,
                       input int          exp_lat,
                       input logic        exp_err);
      int          lat;
      logic [31:0] rd;
      logic        er;
      do_req(w, f3, a, d, lat, rd, er);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
      check({tag, "_err"}, 64'(er), 64'(exp_err));
      ack(tag);
   endtask

   initial begin
      int n0;
      int lat;
      logic [31:0] rd;
      logic        er;
      logic [7:0]  sw_b [4];
      sw_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[12] = 8'h7F;

      #2;
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      check("rst_resp_err", 64'(resp_err), 64'd0);
      check("rst_mem_en", 64'(mem_en), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd1);

      // SW 0xDEADBEEF at 8: one byte per cycle C1..C4.
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
      xact("sw8", 1'b1, F3_W, 32'd8, 32'hDEADBEEF, 32'h0, 5, 1'b0);
      check("sw8_nwr", 64'(wr_cyc.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < wr_cyc.size()) begin
            check("sw8_wcyc", 64'(wr_cyc[k]), 64'(c0 + 1 + k));
            check("sw8_waddr", 64'(wr_addr[k]), 64'(8 + k));
            check("sw8_wdata", 64'(wr_data[k]), 64'(sw_b[k]));
         end
      end

      xact("lb9", 1'b0, F3_B, 32'd9, 32'h0, 32'hFFFFFFBE, 3, 1'b0);
      xact("lbu9", 1'b0, F3_BU, 32'd9, 32'h0, 32'h000000BE, 3, 1'b0);
      xact("lh11", 1'b0, F3_H, 32'd11, 32'h0, 32'h00007FDE, 4, 1'b0);
      xact("lh9", 1'b0, F3_H, 32'd9, 32'h0, 32'hFFFFADBE, 4, 1'b0);
      xact("lhu9", 1'b0, F3_HU, 32'd9, 32'h0, 32'h0000ADBE, 4, 1'b0);
      xact("lw8", 1'b0, F3_W, 32'd8, 32'h0, 32'hDEADBEEF, 6, 1'b0);
      xact("lw9", 1'b0, F3_W, 32'd9, 32'h0, 32'h7FDEADBE, 6, 1'b0);
      xact("sh20", 1'b1, F3_H, 32'd20, 32'hAAAA8123, 32'h0, 3, 1'b0);
      xact("lw20", 1'b0, F3_W, 32'd20, 32'h0, 32'h00008123, 6, 1'b0);
      xact("sb1023", 1'b1, F3_B, 32'd1023, 32'h000000C3, 32'h0, 2, 1'b0);
      xact("lb1023", 1'b0, F3_B, 32'd1023, 32'h0, 32'hFFFFFFC3, 3, 1'b0);

      // Error requests never touch memory.
      n0 = n_en;
      xact("f3_011", 1'b0, 3'b011, 32'd0, 32'h0, 32'h0, 1, 1'b1);
      xact("lh1023", 1'b0, F3_H, 32'd1023, 32'h0, 32'h0, 1, 1'b1);
      xact("sbu_ill", 1'b1, F3_BU, 32'd0, 32'h0, 32'h0, 1, 1'b1);
      xact("wrap", 1'b0, F3_W, 32'hFFFFFFFE, 32'h0, 32'h0, 1, 1'b1);
      do_req(1'b0, F3_W, 32'd1021, 32'h0, lat, rd, er);
      check("lw1021_lat", 64'(lat), 64'd1);
      check("lw1021_err", 64'(er), 64'd1);
      check("lw1021_rdata", 64'(rd), 64'd0);

      // Stall the response while poking req_* with a store.
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         req_valid  = 1'b1;
         req_write  = 1'b1;
         req_funct3 = F3_W;
         req_addr   = 32'd40;
         req_wdata  = 32'h55555555;
         @(posedge clock);
         #1;
         check("stall_valid", 64'(resp_valid), 64'd1);
         check("stall_err", 64'(resp_err), 64'd1);
         check("stall_rdata", 64'(resp_rdata), 64'd0);
         check("stall_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      ack("lw1021");
      check("err_no_mem_en", 64'(n_en - n0), 64'd0);
      check("busy_no_write", 64'(mem[40]), 64'd0);

      // Reset in C2 of a store: only byte 0 lands.
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
      @(negedge clock);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = F3_W;
      req_addr   = 32'd8;
      req_wdata  = 32'h11223344;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      check("arst_mem_en", 64'(mem_en), 64'd0);
      check("arst_mem_addr", 64'(mem_addr), 64'd0);
      check("arst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("arst_resp_valid", 64'(resp_valid), 64'd0);
      check("arst_req_ready", 64'(req_ready), 64'd1);
      @(negedge clock);
      reset_n = 1'b1;
      n0 = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         #1;
         if (resp_valid) n0++;
      end
      check("arst_no_resp", 64'(n0), 64'd0);
      check("arst_nwr", 64'(wr_cyc.size()), 64'd1);
      check("arst_b8", 64'(mem[8]), 64'h44);
      check("arst_b9", 64'(mem[9]), 64'hBE);

      xact("post_rst_lb8", 1'b0, F3_BU, 32'd8, 32'h0, 32'h44, 3, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
